// File: rtl/subtractor_pipe_pkg.sv
// Shared arithmetic constants and stage payload types for the 6-bit subtractor pipeline.
package subtractor_pipe_pkg;

  localparam int unsigned WIDTH  = 6;
  localparam int unsigned STAGES = 2;

  typedef logic [WIDTH-1:0] word_t;

  typedef struct packed {
    word_t gb;
    word_t pb;
    word_t h;
  } s1_t;

  typedef struct packed {
    word_t d;
    logic  bo;
  } s2_t;

  // Per-bit borrow generate/propagate and half-difference for x - y.
  function automatic s1_t s1_encode(word_t x, word_t y);
    s1_t s;
    s.gb = ~x & y;
    s.pb = ~(x ^ y);
    s.h  = x ^ y;
    return s;
  endfunction

endpackage

// File: rtl/subtractor_pipe_if.sv
// Operand/result handshake bundle for subtractor_pipe; bit-level names match the block pinout.
interface subtractor_pipe_if;

  logic x0, x1, x2, x3, x4, x5;
  logic y0, y1, y2, y3, y4, y5;
  logic in_valid;
  logic in_ready;
  logic d0, d1, d2, d3, d4, d5;
  logic bo;
  logic out_valid;
  logic out_ready;

  modport master (
    output x0, x1, x2, x3, x4, x5,
    output y0, y1, y2, y3, y4, y5,
    output in_valid, out_ready,
    input  in_ready, d0, d1, d2, d3, d4, d5, bo, out_valid
  );

  modport slave (
    input  x0, x1, x2, x3, x4, x5,
    input  y0, y1, y2, y3, y4, y5,
    input  in_valid, out_ready,
    output in_ready, d0, d1, d2, d3, d4, d5, bo, out_valid
  );

endinterface

// File: rtl/borrow_prefix6.sv
// Kogge-Stone prefix borrow network: B[i] is the borrow into bit i, B[6] the borrow out.
module borrow_prefix6
  import subtractor_pipe_pkg::*;
(
  input  logic [WIDTH-1:0] gb,
  input  logic [WIDTH-1:0] pb,
  output logic [WIDTH:0]   B
);

  // Borrow into bit 0 is always zero.
  localparam logic B0 = 1'b0;

  logic [WIDTH-1:0] g1, g2, g3;
  logic [WIDTH-1:2] p1;
  logic [WIDTH-1:4] p2;

  always_comb begin
    g1[0] = gb[0] | (pb[0] & B0);
    for (int i = 1; i < 6; i++) g1[i] = gb[i] | (pb[i] & gb[i-1]);
    for (int i = 2; i < 6; i++) p1[i] = pb[i] & pb[i-1];

    g2[1:0] = g1[1:0];
    for (int i = 2; i < 6; i++) g2[i] = g1[i] | (p1[i] & g1[i-2]);
    for (int i = 4; i < 6; i++) p2[i] = p1[i] & p1[i-2];

    g3[3:0] = g2[3:0];
    for (int i = 4; i < 6; i++) g3[i] = g2[i] | (p2[i] & g2[i-4]);

    B = {g3, B0};
  end

endmodule

// File: rtl/subtractor_pipe.sv
// Two-stage valid/ready subtractor: S1 holds generate/propagate/half-difference, S2 the result.
module subtractor_pipe
  import subtractor_pipe_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  subtractor_pipe_if.slave bus
);

  word_t             x, y;
  logic [STAGES-1:0] vld_q, vld_d;
  s1_t               s1_q, s1_d;
  s2_t               s2_q, s2_d;
  logic              s1_ready, s2_ready;
  logic [WIDTH:0]    borrow;

  assign x = {bus.x5, bus.x4, bus.x3, bus.x2, bus.x1, bus.x0};
  assign y = {bus.y5, bus.y4, bus.y3, bus.y2, bus.y1, bus.y0};

  borrow_prefix6 u_prefix (
    .gb (s1_q.gb),
    .pb (s1_q.pb),
    .B  (borrow)
  );

  // A stage loads when empty or when the stage after it moves on this cycle.
  always_comb begin
    s2_ready = ~vld_q[1] | bus.out_ready;
    s1_ready = ~vld_q[0] | s2_ready;
    vld_d    = vld_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    if (s1_ready) begin
      vld_d[0] = bus.in_valid;
      if (bus.in_valid) s1_d = s1_encode(x, y);
    end
    if (s2_ready) begin
      vld_d[1] = vld_q[0];
      if (vld_q[0]) begin
        s2_d.d  = s1_q.h ^ borrow[WIDTH-1:0];
        s2_d.bo = borrow[WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
    end else begin
      vld_q <= vld_d;
      s1_q  <= s1_d;
      s2_q  <= s2_d;
    end
  end

  assign bus.in_ready  = s1_ready;
  assign bus.out_valid = vld_q[1];
  assign bus.bo        = s2_q.bo;
  assign {bus.d5, bus.d4, bus.d3, bus.d2, bus.d1, bus.d0} = s2_q.d;

endmodule

// File: tb/tb_subtractor_pipe.sv
// Self-checking bench for subtractor_pipe: directed vectors, backpressure/reset sequences, random.
module tb_subtractor_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  subtractor_pipe_if bus ();

  subtractor_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int x;
    int y;
    int d;
    int bo;
  } vec_t;

  vec_t tbl[8];
  int   n_pass  = 0;
  int   n_total = 0;
  int   n_out   = 0;
  int   exp_q[$];
  int   got_q[$];
  bit   hold    = 1'b0;
  int   held    = 0;

  // Result encoded as bo*64 + d, derived from plain integer arithmetic.
  function automatic int ref_sub(int xv, int yv);
    int dv = ((xv - yv) % 64 + 64) % 64;
    return ((xv < yv) ? 64 : 0) + dv;
  endfunction

  function automatic int get_d();
    return int'({bus.d5, bus.d4, bus.d3, bus.d2, bus.d1, bus.d0});
  endfunction

  function automatic int get_res();
    return int'(bus.bo) * 64 + get_d();
  endfunction

  task automatic check(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(logic v, logic [5:0] xv, logic [5:0] yv);
    bus.in_valid = v;
    {bus.x5, bus.x4, bus.x3, bus.x2, bus.x1, bus.x0} = xv;
    {bus.y5, bus.y4, bus.y3, bus.y2, bus.y1, bus.y0} = yv;
  endtask

  // Scoreboard one clock: judge the transfers the coming edge performs, then advance.
  task automatic step(output bit acc);
    int xv, yv, e;
    #1;
    if (hold) begin
      check("hold_valid", int'(bus.out_valid), 1);
      check("hold_data", get_res(), held);
    end
    hold = bus.out_valid & ~bus.out_ready;
    held = get_res();
    acc  = bus.in_valid & bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      got_q.push_back(get_res());
      n_out++;
      if (exp_q.size() == 0) check("out_when_empty", int'(bus.out_valid), 0);
      else begin
        e = exp_q.pop_front();
        check("result", get_res(), e);
      end
    end
    if (acc) begin
      xv = int'({bus.x5, bus.x4, bus.x3, bus.x2, bus.x1, bus.x0});
      yv = int'({bus.y5, bus.y4, bus.y3, bus.y2, bus.y1, bus.y0});
      exp_q.push_back(ref_sub(xv, yv));
    end
    @(negedge clk);
  endtask

  initial begin
    bit acc;
    int n_acc;
    int out_base;

    tbl[0] = '{x: 5,  y: 3,  d: 2,  bo: 0};
    tbl[1] = '{x: 3,  y: 5,  d: 62, bo: 1};
    tbl[2] = '{x: 0,  y: 1,  d: 63, bo: 1};
    tbl[3] = '{x: 63, y: 63, d: 0,  bo: 0};
    tbl[4] = '{x: 0,  y: 0,  d: 0,  bo: 0};
    tbl[5] = '{x: 10, y: 3,  d: 7,  bo: 0};
    tbl[6] = '{x: 32, y: 33, d: 63, bo: 1};
    tbl[7] = '{x: 63, y: 0,  d: 63, bo: 0};

    bus.out_ready = 1'b1;
    drive(1'b1, 6'd21, 6'd9);

    // Reset state, operands offered but must be ignored.
    @(negedge clk);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_d", get_d(), 0);
    check("rst_bo", int'(bus.bo), 0);
    @(negedge clk);
    check("rst_out_valid_hold", int'(bus.out_valid), 0);
    rst = 1'b0;

    // Directed vectors; the first is accepted on the first edge after reset release.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 6'(tbl[i].x), 6'(tbl[i].y));
      @(negedge clk);
      drive(1'b0, 6'd0, 6'd0);
      check("lat_early_valid", int'(bus.out_valid), 0);
      @(negedge clk);
      check("lat2_valid", int'(bus.out_valid), 1);
      check("vec_d", get_d(), tbl[i].d);
      check("vec_bo", int'(bus.bo), tbl[i].bo);
      @(negedge clk);
      check("one_cycle_valid", int'(bus.out_valid), 0);
    end

    // Backpressure: two accepts fill the pipe, third operand must wait.
    got_q.delete();
    bus.out_ready = 1'b0;
    drive(1'b1, 6'd7, 6'd2);
    step(acc);
    check("bp_acc_a", int'(acc), 1);
    drive(1'b1, 6'd1, 6'd4);
    step(acc);
    check("bp_acc_b", int'(acc), 1);
    drive(1'b1, 6'd40, 6'd40);
    check("bp_full_in_ready", int'(bus.in_ready), 0);
    check("bp_first_valid", int'(bus.out_valid), 1);
    check("bp_first_res", get_res(), 5);
    step(acc);
    check("bp_no_accept", int'(acc), 0);
    step(acc);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 12 && (bus.in_valid || exp_q.size() > 0); c++) begin
      step(acc);
      if (acc) bus.in_valid = 1'b0;
    end
    check("bp_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("bp_res0", got_q[0], 5);
      check("bp_res1", got_q[1], 64 + 61);
      check("bp_res2", got_q[2], 0);
    end

    // Reset with two operations in flight.
    drive(1'b1, 6'd20, 6'd5);
    step(acc);
    drive(1'b1, 6'd9, 6'd12);
    step(acc);
    drive(1'b0, 6'd0, 6'd0);
    check("inflight_valid", int'(bus.out_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", int'(bus.out_valid), 0);
    check("async_rst_in_ready", int'(bus.in_ready), 1);
    check("async_rst_d", get_d(), 0);
    exp_q.delete();
    hold = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("post_rst_idle", int'(bus.out_valid), 0);
      step(acc);
    end
    drive(1'b1, 6'd10, 6'd3);
    step(acc);
    check("post_rst_acc", int'(acc), 1);
    drive(1'b0, 6'd0, 6'd0);
    check("post_rst_lat1", int'(bus.out_valid), 0);
    step(acc);
    check("post_rst_lat2", int'(bus.out_valid), 1);
    check("post_rst_res", get_res(), 7);
    step(acc);

    // Random operands with random valid/ready against the arithmetic model.
    got_q.delete();
    out_base = n_out;
    n_acc    = 0;
    for (int c = 0; c < 60000 && n_acc < 10000; c++) begin
      drive(logic'($urandom_range(0, 3) != 0), 6'($urandom), 6'($urandom));
      bus.out_ready = logic'($urandom_range(0, 3) != 0);
      step(acc);
      if (acc) n_acc++;
      if (got_q.size() > 64) got_q.delete();
    end
    check("random_ops", n_acc, 10000);
    drive(1'b0, 6'd0, 6'd0);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) step(acc);
    check("drain_empty", exp_q.size(), 0);
    check("random_outputs", n_out - out_base, n_acc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
